// File: rtl/shift_chain_pkg.sv
// Shared definitions for the shift-chain sequencer.
//   state_t     : controller FSM encoding (ST_IDLE, ST_SHIFT, ST_DONE)
//   MODE_*      : shift-mode constants for the stage-0 input mux
//   div_width() : divider counter width, at least one bit even when DIV=1
package shift_chain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic MODE_FILL   = 1'b0;
    localparam logic MODE_ROTATE = 1'b1;

    function automatic int div_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One WIDTH-bit stage of the shift chain.
//   clk       : clock
//   rst       : synchronous, active-high reset (clears q)
//   load      : take load_word (wins over en)
//   load_word : parallel-load value
//   en        : take ser_in (one shift step)
//   ser_in    : serial input from the previous stage or the stage-0 mux
//   q         : stage contents
module shift_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_word,
    input  logic             en,
    input  logic [WIDTH-1:0] ser_in,
    output logic [WIDTH-1:0] q
);

    // NOTE: non-blocking assignment so every stage samples its neighbour's
    // old value on the same edge; blocking here would smear one word down
    // the whole chain in a single step.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_word;
        end else if (en) begin
            q <= ser_in;
        end
    end

endmodule

// File: rtl/shift_chain_ctrl.sv
// Sequencer for a chain of STAGES parallel-loadable WIDTH-bit stages.
// A start in IDLE loads the chain and latches count/mode/fill; the chain
// then shifts once every DIV clocks (frozen while hold is high) until the
// programmed count is exhausted, followed by a single DONE cycle.
//   clk, rst    : clock; synchronous active-high reset
//   start       : operation request, honoured only in IDLE
//   load_data   : initial chain, slice [i*WIDTH +: WIDTH] -> stage i
//   shift_count : number of shifts K (0 goes straight to DONE)
//   mode        : 0 = fill (stage 0 takes fill_data), 1 = rotate
//   fill_data   : stage-0 word in fill mode
//   hold        : freezes divider, count and chain during SHIFT
//   stages_out  : chain contents, same slice mapping as load_data
//   busy        : state != IDLE
//   done        : high for the single DONE cycle
module shift_chain_ctrl
    import shift_chain_pkg::*;
#(
    parameter int STAGES = 4,
    parameter int WIDTH  = 8,
    parameter int DIV    = 1,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [STAGES*WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0]        shift_count,
    input  logic                    mode,
    input  logic [WIDTH-1:0]        fill_data,
    input  logic                    hold,
    output logic [STAGES*WIDTH-1:0] stages_out,
    output logic                    busy,
    output logic                    done
);

    localparam int               DIV_W    = div_width(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    state_t                  state, state_nx;
    logic [DIV_W-1:0]        div_cnt;
    logic [CNT_W-1:0]        remaining;
    logic                    mode_q;
    logic [WIDTH-1:0]        fill_q;
    logic                    accept;
    logic                    step;
    logic [STAGES*WIDTH-1:0] chain;
    logic [WIDTH-1:0]        stage0_in;

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        step     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = (shift_count == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!hold && div_cnt == DIV_LAST) begin
                    step = 1'b1;
                    // Last shift: remaining goes 1 -> 0 on this edge.
                    if (remaining == CNT_W'(1)) begin
                        state_nx = ST_DONE;
                    end
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            remaining <= '0;
            mode_q    <= MODE_FILL;
            fill_q    <= '0;
        end else if (accept) begin
            div_cnt   <= '0;
            remaining <= shift_count;
            mode_q    <= mode;
            fill_q    <= fill_data;
        end else if (state == ST_SHIFT && !hold) begin
            if (step) begin
                div_cnt   <= '0;
                remaining <= remaining - CNT_W'(1);
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    assign stage0_in = (mode_q == MODE_ROTATE) ? chain[(STAGES-1)*WIDTH +: WIDTH]
                                               : fill_q;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [WIDTH-1:0] ser;
        if (i == 0) begin : g_head
            assign ser = stage0_in;
        end else begin : g_body
            assign ser = chain[(i-1)*WIDTH +: WIDTH];
        end

        shift_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .load      (accept),
            .load_word (load_data[i*WIDTH +: WIDTH]),
            .en        (step),
            .ser_in    (ser),
            .q         (chain[i*WIDTH +: WIDTH])
        );
    end

    assign stages_out = chain;
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_shift_chain_ctrl.sv
module tb_shift_chain_ctrl;

    localparam int STAGES = 4;
    localparam int WIDTH  = 8;
    localparam int CNT_W  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [31:0] load_data;
    logic [7:0]  shift_count;
    logic        mode;
    logic [7:0]  fill_data;
    logic        hold;
    logic [31:0] so_a, so_b;
    logic        busy_a, busy_b, done_a, done_b;

    // Two instances: DIV=1 (a) and DIV=2 (b), separate start lines.
    shift_chain_ctrl #(.STAGES(STAGES), .WIDTH(WIDTH), .DIV(1), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .load_data(load_data),
        .shift_count(shift_count), .mode(mode), .fill_data(fill_data), .hold(hold),
        .stages_out(so_a), .busy(busy_a), .done(done_a)
    );

    shift_chain_ctrl #(.STAGES(STAGES), .WIDTH(WIDTH), .DIV(2), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .load_data(load_data),
        .shift_count(shift_count), .mode(mode), .fill_data(fill_data), .hold(hold),
        .stages_out(so_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    logic        cur;
    logic [31:0] so;
    logic        busy, done;
    assign so   = cur ? so_b   : so_a;
    assign busy = cur ? busy_b : busy_a;
    assign done = cur ? done_b : done_a;

    typedef struct {
        logic        sel;
        logic [31:0] load;
        logic [7:0]  k;
        logic        mode;
        logic [7:0]  fill;
        logic [31:0] final_v;
        int          lat;      // cycles from E0 to the done cycle = K*DIV
    } vec_t;

    typedef struct {
        logic [31:0] final_v;
        int          lat;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input vec_t v);
        exp_t e;
        int   waited;
        cur         = v.sel;
        load_data   = v.load;
        shift_count = v.k;
        mode        = v.mode;
        fill_data   = v.fill;
        if (v.sel) start_b = 1'b1;
        else       start_a = 1'b1;
        sb.push_back('{final_v: v.final_v, lat: v.lat});
        tick();                                   // E0
        start_a = 1'b0;
        start_b = 1'b0;
        check("loaded", so, v.load);
        check("busy_after_e0", 32'(busy), 32'd1);
        waited = 0;
        while (!done && waited < v.lat + 20) begin
            tick();
            waited++;
        end
        e = sb.pop_front();
        check("done_seen", 32'(done), 32'd1);
        check("done_latency", 32'(waited), 32'(e.lat));
        check("final_value", so, e.final_v);
        tick();
        check("idle_after_done", 32'({busy, done}), 32'd0);
        check("final_held", so, e.final_v);
    endtask

    initial begin
        logic saw_done;

        //          sel   load_data      K      mode  fill   final          lat
        vecs[0] = '{1'b0, 32'h44332211, 8'd1,   1'b1, 8'h00, 32'h33221144,  1};
        vecs[1] = '{1'b1, 32'h44332211, 8'd2,   1'b0, 8'h00, 32'h22110000,  4};
        vecs[2] = '{1'b0, 32'hA5A5A5A5, 8'd0,   1'b0, 8'h00, 32'hA5A5A5A5,  0};
        vecs[3] = '{1'b0, 32'h44332211, 8'd4,   1'b1, 8'h00, 32'h44332211,  4};
        vecs[4] = '{1'b0, 32'h12345678, 8'd3,   1'b0, 8'hEE, 32'h78EEEEEE,  3};
        vecs[5] = '{1'b1, 32'hDDCCBBAA, 8'd5,   1'b1, 8'h00, 32'hCCBBAADD, 10};
        vecs[6] = '{1'b0, 32'h04030201, 8'd6,   1'b1, 8'h00, 32'h02010403,  6};
        vecs[7] = '{1'b0, 32'h01020304, 8'd255, 1'b0, 8'h5A, 32'h5A5A5A5A, 255};

        cur = 1'b0; rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        load_data = '0; shift_count = '0; mode = 1'b0; fill_data = '0; hold = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_so_a", so_a, 32'h0);
        check("reset_so_b", so_b, 32'h0);
        check("reset_flags", 32'({busy_a, done_a, busy_b, done_b}), 32'd0);

        // Table vectors run back to back: each start lands in the IDLE
        // cycle right after the previous done.
        for (int i = 0; i < 8; i++) run_op(vecs[i]);

        // Hold for two cycles after the first shift, plus a start while busy.
        cur = 1'b0;
        load_data = 32'h44332211; shift_count = 8'd3; mode = 1'b1; fill_data = 8'h00;
        start_a = 1'b1;
        tick();                                   // E0
        start_a = 1'b0;
        check("hold_load", so_a, 32'h44332211);
        tick();                                   // E1: first shift
        check("hold_shift1", so_a, 32'h33221144);
        hold = 1'b1;
        start_a = 1'b1; load_data = 32'hFFFFFFFF; shift_count = 8'd9;
        tick();                                   // E2 held
        check("hold_frozen1", so_a, 32'h33221144);
        tick();                                   // E3 held
        check("hold_frozen2", so_a, 32'h33221144);
        check("hold_busy", 32'({busy_a, done_a}), 32'd2);
        hold = 1'b0; start_a = 1'b0;
        tick();                                   // E4
        check("hold_shift2", so_a, 32'h22114433);
        check("hold_no_early_done", 32'(done_a), 32'd0);
        tick();                                   // E5
        check("hold_shift3", so_a, 32'h11443322);
        check("hold_done", 32'({busy_a, done_a}), 32'd3);
        tick();
        check("hold_idle", 32'({busy_a, done_a}), 32'd0);
        check("hold_final", so_a, 32'h11443322);

        // Reset in the middle of a long rotate.
        load_data = 32'hCAFEBABE; shift_count = 8'd10; mode = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        tick();
        check("pre_reset_busy", 32'(busy_a), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_so", so_a, 32'h0);
        check("midrst_flags", 32'({busy_a, done_a}), 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done_a || busy_a) saw_done = 1'b1;
        end
        check("midrst_no_done", 32'(saw_done), 32'd0);

        // Normal operation after reset.
        run_op(vecs[0]);
        run_op(vecs[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
